// File: rtl/frame_timing_gen.sv
`default_nettype none
// ==========================================================================
// frame_timing_gen : configurable vsync/hsync/AXI-Stream frame timing FSM
// Rev 1.0
// ==========================================================================
module frame_timing_gen #(
  parameter int CNT_W      = 16,
  parameter int VSYNC_LEN  = 16,
  parameter int HSYNC_LEN  = 6,
  parameter int HBLANK_LEN = 4,
  parameter int FS_DLY     = 12
) (
  input  logic             eim_clk,
  input  logic             eim_rst,
  input  logic             tx_eim_rst_n,
  input  logic [CNT_W-1:0] cfg_h_active,
  input  logic [CNT_W-1:0] cfg_v_active,
  input  logic             frame_req,
  input  logic             abort,
  input  logic             m_axis_tready,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             sig_vsync,
  output logic             sig_hsync,
  output logic             frame_busy,
  output logic             frame_done,
  output logic             read_frame_start,
  output logic             cfg_err
);

  localparam int c_LEN_MAX = (VSYNC_LEN > HSYNC_LEN)
                           ? ((VSYNC_LEN > HBLANK_LEN) ? VSYNC_LEN : HBLANK_LEN)
                           : ((HSYNC_LEN > HBLANK_LEN) ? HSYNC_LEN : HBLANK_LEN);
  localparam int c_LEN_W = (c_LEN_MAX > 1) ? $clog2(c_LEN_MAX) : 1;
  localparam logic [c_LEN_W-1:0] c_VS_LAST = c_LEN_W'(VSYNC_LEN - 1);
  localparam logic [c_LEN_W-1:0] c_HS_LAST = c_LEN_W'(HSYNC_LEN - 1);
  localparam logic [c_LEN_W-1:0] c_HB_LAST = c_LEN_W'(HBLANK_LEN - 1);
  localparam logic [c_LEN_W-1:0] c_LEN_ONE = c_LEN_W'(1);
  localparam logic [CNT_W-1:0]   c_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]   c_TWO     = CNT_W'(2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_HSYNC  = 3'd2,
    S_ACTIVE = 3'd3,
    S_HBLANK = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [c_LEN_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]   r_h, w_h_nxt, r_v, w_v_nxt;
  logic [CNT_W-1:0]   r_h_act, r_v_act;
  logic               r_tvalid, r_tlast, r_tuser, r_vsync, r_hsync;
  logic               r_busy, r_done, r_err, r_rfs;
  logic               w_err_nxt, w_latch, w_flush, w_fs_hs;
  logic [FS_DLY-1:0]  r_fs_sr;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_h_nxt     = r_h;
    w_v_nxt     = r_v;
    w_err_nxt   = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_req && !abort) begin
          if (cfg_h_active >= c_TWO && cfg_v_active != '0) begin
            w_state_nxt = S_VSYNC;
            w_cnt_nxt   = '0;
            w_h_nxt     = '0;
            w_v_nxt     = '0;
            w_latch     = 1'b1;
          end else begin
            w_err_nxt   = 1'b1;
          end
        end
      end
      S_VSYNC: begin
        if (r_cnt == c_VS_LAST) begin
          w_state_nxt = S_HSYNC;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + c_LEN_ONE;
        end
      end
      S_HSYNC: begin
        if (r_cnt == c_HS_LAST) begin
          w_state_nxt = S_ACTIVE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + c_LEN_ONE;
        end
      end
      S_ACTIVE: begin
        if (m_axis_tready) begin
          if (r_h == r_h_act - c_ONE) begin
            w_h_nxt = '0;
            if (r_v == r_v_act - c_ONE) begin
              w_state_nxt = S_DONE;
              w_v_nxt     = '0;
            end else begin
              w_state_nxt = S_HBLANK;
              w_v_nxt     = r_v + c_ONE;
              w_cnt_nxt   = '0;
            end
          end else begin
            w_h_nxt = r_h + c_ONE;
          end
        end
      end
      S_HBLANK: begin
        if (r_cnt == c_HB_LAST) begin
          w_state_nxt = S_HSYNC;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + c_LEN_ONE;
        end
      end
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    // Abort and soft clear both land in IDLE with everything zeroed.
    if ((abort && r_state != S_IDLE) || !tx_eim_rst_n) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_h_nxt     = '0;
      w_v_nxt     = '0;
      w_err_nxt   = 1'b0;
      w_latch     = 1'b0;
    end
  end

  assign w_flush = (abort && r_state != S_IDLE) || !tx_eim_rst_n;
  assign w_fs_hs = r_tuser & r_tvalid & m_axis_tready;

  always_ff @(posedge eim_clk or posedge eim_rst) begin
    if (eim_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_h      <= '0;
      r_v      <= '0;
      r_h_act  <= '0;
      r_v_act  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tuser  <= 1'b0;
      r_vsync  <= 1'b0;
      r_hsync  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_rfs    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_h      <= w_h_nxt;
      r_v      <= w_v_nxt;
      if (w_latch) begin
        r_h_act <= cfg_h_active;
        r_v_act <= cfg_v_active;
      end
      r_tvalid <= (w_state_nxt == S_ACTIVE);
      r_tlast  <= (w_state_nxt == S_ACTIVE) && (w_h_nxt == r_h_act - c_ONE);
      r_tuser  <= (w_state_nxt == S_ACTIVE) && (w_h_nxt == '0) && (w_v_nxt == '0);
      r_vsync  <= (w_state_nxt == S_VSYNC);
      r_hsync  <= (w_state_nxt == S_HSYNC);
      r_busy   <= (w_state_nxt != S_IDLE);
      r_done   <= (w_state_nxt == S_DONE);
      r_err    <= w_err_nxt;
      r_rfs    <= w_flush ? 1'b0 : r_fs_sr[FS_DLY-1];
    end
  end

  generate
    if (FS_DLY == 1) begin : g_fs_one
      always_ff @(posedge eim_clk or posedge eim_rst) begin
        if (eim_rst) r_fs_sr <= '0;
        else         r_fs_sr <= w_flush ? 1'b0 : w_fs_hs;
      end
    end else begin : g_fs_shift
      always_ff @(posedge eim_clk or posedge eim_rst) begin
        if (eim_rst) r_fs_sr <= '0;
        else         r_fs_sr <= w_flush ? '0 : {r_fs_sr[FS_DLY-2:0], w_fs_hs};
      end
    end
  endgenerate

  assign m_axis_tvalid    = r_tvalid;
  assign m_axis_tlast     = r_tlast;
  assign m_axis_tuser     = r_tuser;
  assign h_count          = r_h;
  assign v_count          = r_v;
  assign sig_vsync        = r_vsync;
  assign sig_hsync        = r_hsync;
  assign frame_busy       = r_busy;
  assign frame_done       = r_done;
  assign read_frame_start = r_rfs;
  assign cfg_err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_frame_timing_gen.sv
`default_nettype none
// tb_frame_timing_gen: directed vector table plus hand-written multi-cycle sequences
module tb_frame_timing_gen;
  logic        clk = 1'b0;
  logic        eim_rst, tx_eim_rst_n, frame_req, abort, tready;
  logic [15:0] cfg_h, cfg_v;
  logic        tvalid, tlast, tuser, vsync, hsync, busy, done, rfs, err;
  logic [15:0] h_count, v_count;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  frame_timing_gen dut (
    .eim_clk(clk), .eim_rst(eim_rst), .tx_eim_rst_n(tx_eim_rst_n),
    .cfg_h_active(cfg_h), .cfg_v_active(cfg_v), .frame_req(frame_req), .abort(abort),
    .m_axis_tready(tready), .m_axis_tvalid(tvalid), .m_axis_tlast(tlast), .m_axis_tuser(tuser),
    .h_count(h_count), .v_count(v_count), .sig_vsync(vsync), .sig_hsync(hsync),
    .frame_busy(busy), .frame_done(done), .read_frame_start(rfs), .cfg_err(err)
  );

  typedef struct {
    logic        req;
    logic        abrt;
    logic        rdy;
    logic [15:0] ha;
    logic [15:0] va;
    logic [39:0] exp;
  } vec_t;
  vec_t vq[$];

  function automatic logic [39:0] pk(input logic vl, ls, us, vs, hs, bz, dn, er,
                                      input logic [15:0] h, v);
    return {vl, ls, us, vs, hs, bz, dn, er, h, v};
  endfunction

  function automatic logic [39:0] act();
    return {tvalid, tlast, tuser, vsync, hsync, busy, done, err, h_count, v_count};
  endfunction

  task automatic add(input int n, input logic rq, ab, rd, input logic [15:0] ha, va,
                     input logic [39:0] ex);
    for (int i = 0; i < n; i++) vq.push_back('{rq, ab, rd, ha, va, ex});
  endtask

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, a, e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [15:0] ha, va);
    cfg_h = ha; cfg_v = va; frame_req = 1'b1;
    step();
    frame_req = 1'b0;
  endtask

  task automatic run_count(input int budget, output int beats, output int dones);
    beats = 0; dones = 0;
    for (int c = 0; c < budget; c++) begin
      if (tvalid && tready) beats++;
      step();
      if (done) begin dones++; break; end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   beats, dones, hs_cnt, stall_bad, last_bad, user_bad, rfs_seen;
    logic found, pre_v, pre_last, pre_user, pre_rdy;
    logic [15:0] pre_h;

    eim_rst = 1'b1; tx_eim_rst_n = 1'b1; frame_req = 1'b0; abort = 1'b0;
    tready = 1'b0; cfg_h = 16'd0; cfg_v = 16'd0;
    step(); step();
    chk("reset_outputs", act(), 40'd0);
    chk("reset_rfs", rfs, 0);
    eim_rst = 1'b0;
    step();

    // Full 4x2 frame with tready held high.
    add(1,  1, 0, 1, 4, 2, pk(0,0,0,1,0,1,0,0, 0,0));
    add(15, 0, 0, 1, 4, 2, pk(0,0,0,1,0,1,0,0, 0,0));
    add(6,  0, 0, 1, 4, 2, pk(0,0,0,0,1,1,0,0, 0,0));
    add(1,  0, 0, 1, 4, 2, pk(1,0,1,0,0,1,0,0, 0,0));
    add(1,  0, 0, 1, 4, 2, pk(1,0,0,0,0,1,0,0, 1,0));
    add(1,  0, 0, 1, 4, 2, pk(1,0,0,0,0,1,0,0, 2,0));
    add(1,  0, 0, 1, 4, 2, pk(1,1,0,0,0,1,0,0, 3,0));
    add(4,  0, 0, 1, 4, 2, pk(0,0,0,0,0,1,0,0, 0,1));
    add(6,  0, 0, 1, 4, 2, pk(0,0,0,0,1,1,0,0, 0,1));
    add(1,  0, 0, 1, 4, 2, pk(1,0,0,0,0,1,0,0, 0,1));
    add(1,  0, 0, 1, 4, 2, pk(1,0,0,0,0,1,0,0, 1,1));
    add(1,  0, 0, 1, 4, 2, pk(1,0,0,0,0,1,0,0, 2,1));
    add(1,  0, 0, 1, 4, 2, pk(1,1,0,0,0,1,0,0, 3,1));
    add(1,  0, 0, 1, 4, 2, pk(0,0,0,0,0,1,1,0, 0,0));
    add(1,  0, 0, 1, 4, 2, pk(0,0,0,0,0,0,0,0, 0,0));
    // Rejected configs, abort beating frame_req, max-width line accepted then aborted.
    add(1,  1, 0, 1, 1, 1, pk(0,0,0,0,0,0,0,1, 0,0));
    add(1,  0, 0, 1, 1, 1, pk(0,0,0,0,0,0,0,0, 0,0));
    add(1,  1, 0, 1, 3, 0, pk(0,0,0,0,0,0,0,1, 0,0));
    add(1,  1, 1, 1, 2, 1, pk(0,0,0,0,0,0,0,0, 0,0));
    add(1,  1, 0, 1, 16'hFFFF, 1, pk(0,0,0,1,0,1,0,0, 0,0));
    add(1,  0, 1, 1, 16'hFFFF, 1, pk(0,0,0,0,0,0,0,0, 0,0));
    add(1,  0, 0, 1, 16'hFFFF, 1, pk(0,0,0,0,0,0,0,0, 0,0));

    for (int i = 0; i < vq.size(); i++) begin
      frame_req = vq[i].req; abort = vq[i].abrt; tready = vq[i].rdy;
      cfg_h = vq[i].ha; cfg_v = vq[i].va;
      step();
      chk($sformatf("vec%0d", i), act(), vq[i].exp);
    end
    frame_req = 1'b0; abort = 1'b0;

    // tready toggling; cfg change after start must not matter.
    start_frame(4, 2);
    cfg_h = 16'd7; cfg_v = 16'd5;
    hs_cnt = 0; stall_bad = 0; last_bad = 0; user_bad = 0; dones = 0;
    for (int c = 0; c < 200; c++) begin
      tready = (c % 2 == 1);
      pre_v = tvalid; pre_h = h_count; pre_last = tlast; pre_user = tuser; pre_rdy = tready;
      if (tvalid && tready) begin
        hs_cnt++;
        if (tlast !== (h_count == 16'd3)) last_bad++;
        if (tuser !== (h_count == 16'd0 && v_count == 16'd0)) user_bad++;
      end
      step();
      if (pre_v && !pre_rdy && (h_count !== pre_h || tlast !== pre_last || tuser !== pre_user))
        stall_bad++;
      if (done) begin dones++; break; end
    end
    chk("toggle_handshakes", hs_cnt, 8);
    chk("toggle_stall_hold", stall_bad, 0);
    chk("toggle_tlast", last_bad, 0);
    chk("toggle_tuser", user_bad, 0);
    chk("toggle_done", dones, 1);
    step();
    chk("toggle_idle_after", busy, 0);

    // Minimum legal line.
    tready = 1'b1;
    start_frame(2, 1);
    run_count(100, beats, dones);
    chk("h2v1_beats", beats, 2);
    chk("h2v1_done", dones, 1);
    step();

    // Abort at line 1, beat 2 of an 8x4 frame.
    start_frame(8, 4);
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (tvalid && v_count == 16'd1 && h_count == 16'd2) begin found = 1'b1; break; end
      step();
    end
    chk("abort_reach_point", found, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_cleared", act(), 40'd0);
    dones = 0;
    for (int c = 0; c < 20; c++) begin step(); if (done) dones++; end
    chk("abort_no_done", dones, 0);

    // frame_req with bad cfg while busy is ignored; the running frame completes.
    start_frame(2, 1);
    cfg_h = 16'd1; frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    chk("busy_req_ignored", {busy, err}, 2'b10);
    run_count(100, beats, dones);
    chk("after_abort_beats", beats, 2);
    chk("after_abort_done", dones, 1);
    step();

    // read_frame_start timing with a 5-cycle stall on the tuser beat.
    tready = 1'b0;
    start_frame(4, 1);
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (tvalid) begin found = 1'b1; break; end
      step();
    end
    chk("fs_reach_beat0", {found, tuser}, 2'b11);
    rfs_seen = 0;
    for (int c = 0; c < 5; c++) begin step(); if (rfs) rfs_seen++; end
    chk("fs_stall_hold", {tvalid, tuser, h_count}, {2'b11, 16'd0});
    chk("fs_none_during_stall", rfs_seen, 0);
    tready = 1'b1;
    step();
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("fs_dly_k%0d", k), rfs, (k == 12));
    end
    step();
    chk("fs_single_pulse", rfs, 0);
    for (int c = 0; c < 20 && busy; c++) step();

    // Abort shortly after the tuser handshake flushes the delay line.
    start_frame(4, 2);
    for (int c = 0; c < 50 && !tvalid; c++) step();
    step(); step(); step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    rfs_seen = 0;
    for (int c = 0; c < 15; c++) begin step(); if (rfs) rfs_seen++; end
    chk("abort_flush_rfs", rfs_seen, 0);

    // Asynchronous reset mid-ACTIVE after the tuser handshake.
    start_frame(4, 1);
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (tvalid && h_count == 16'd1) begin found = 1'b1; break; end
      step();
    end
    chk("rst_reach_active", found, 1);
    #2;
    eim_rst = 1'b1;
    #1;
    chk("async_rst_outputs", {act(), rfs}, 41'd0);
    step();
    eim_rst = 1'b0;
    rfs_seen = 0;
    for (int c = 0; c < 15; c++) begin step(); if (rfs) rfs_seen++; end
    chk("async_rst_flush", rfs_seen, 0);

    // Synchronous soft clear mid-HSYNC.
    start_frame(4, 1);
    for (int c = 0; c < 50 && !hsync; c++) step();
    tx_eim_rst_n = 1'b0;
    #1;
    chk("soft_clr_sync_only", hsync, 1);
    step();
    chk("soft_clr_outputs", {act(), rfs}, 41'd0);
    tx_eim_rst_n = 1'b1;
    step();
    chk("soft_clr_idle", act(), 40'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
